macguffin_vend_ctrl: RTL and testbench

Parametrised successor to the single-price MacGuffin vending FSM. It accepts debounced quarter, half-dollar and dollar pulses into a credit accumulator. When credit reaches the parameterised price it vends once, then pays back the excess as a paced sequence of half-dollar and quarter pulses. A cancel input refunds the full credit. The block sits between the `debouncer` instances, which produce the coin, cancel and clock-enable pulses, and the `seven_seg` display logic, which renders `credit` and `currentstate`.

---
 rtl/macguffin_vend_ctrl.sv | 133 +++++++++++++
 tb/tb_macguffin_vend_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/macguffin_vend_ctrl.sv
// MacGuffin vending controller: coin credit, one vend at PRICE_Q,
// then paced change payout or full refund on cancel.
module macguffin_vend_ctrl #(
  parameter int unsigned PRICE_Q    = 3,
  parameter int unsigned GAP_CYCLES = 2,
  localparam int unsigned CW = $clog2(PRICE_Q + 4) + 1
) (
  input  logic          CLK50M,
  input  logic          RES,
  input  logic          Q,
  input  logic          H,
  input  logic          D,
  input  logic          CANCEL,
  output logic          Macguffin0,
  output logic          halfDollar0,
  output logic          Quarter0,
  output logic          coin_reject,
  output logic [CW-1:0] credit,
  output logic [1:0]    currentstate
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_e;

  localparam logic [CW-1:0] PRICE = CW'(PRICE_Q);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] TWO   = CW'(2);
  localparam logic [7:0]    GAP   = 8'(GAP_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [7:0]    gap_q, gap_d;
  logic          mac_q, mac_d;
  logic          half_q, half_d;
  logic          qtr_q, qtr_d;
  logic          rej_q, rej_d;

  logic [1:0]    n_coins;
  logic          coin_any;
  logic          coin_ok;
  logic [CW-1:0] coin_val;
  logic [CW-1:0] sum;

  // Coin weights 4/2/1 line up with bit positions of {D,H,Q}.
  always_comb begin
    n_coins  = {1'b0, Q} + {1'b0, H} + {1'b0, D};
    coin_any = Q | H | D;
    coin_ok  = (n_coins == 2'd1);
    coin_val = CW'({D, H, Q});
    sum      = credit_q + coin_val;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    gap_d    = gap_q;
    mac_d    = 1'b0;
    half_d   = 1'b0;
    qtr_d    = 1'b0;
    rej_d    = 1'b0;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (CANCEL) begin
          rej_d = coin_any;
          if (credit_q != '0) begin
            state_d = CHANGE;
            gap_d   = '0;
          end
        end else if (coin_ok) begin
          credit_d = sum;
          state_d  = (sum >= PRICE) ? VEND : COLLECT;
        end else begin
          rej_d = coin_any;
        end
      end
      VEND: begin
        rej_d    = coin_any;
        mac_d    = 1'b1;
        credit_d = credit_q - PRICE;
        gap_d    = '0;
        state_d  = (credit_d != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_d = coin_any;
        if (gap_q == '0) begin
          half_d   = (credit_q >= TWO);
          qtr_d    = ~half_d;
          credit_d = credit_q - (half_d ? TWO : ONE);
          if (credit_d == '0) begin
            state_d = IDLE;
          end else begin
            gap_d = GAP;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK50M) begin
    if (!RES) begin
      state_q  <= IDLE;
      credit_q <= '0;
      gap_q    <= '0;
      mac_q    <= 1'b0;
      half_q   <= 1'b0;
      qtr_q    <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      gap_q    <= gap_d;
      mac_q    <= mac_d;
      half_q   <= half_d;
      qtr_q    <= qtr_d;
      rej_q    <= rej_d;
    end
  end

  assign Macguffin0   = mac_q;
  assign halfDollar0  = half_q;
  assign Quarter0     = qtr_q;
  assign coin_reject  = rej_q;
  assign credit       = credit_q;
  assign currentstate = state_q;

endmodule

// File: tb/tb_macguffin_vend_ctrl.sv
// Bench for macguffin_vend_ctrl: vector table, payout timing
// sequences and a random run against a credit/payout model.
module tb_macguffin_vend_ctrl;

  logic       clk = 1'b0;
  logic       res[3];
  logic       q[3];
  logic       h[3];
  logic       d[3];
  logic       c[3];
  logic       mac[3];
  logic       hd[3];
  logic       qt[3];
  logic       rj[3];
  logic [3:0] cr[3];
  logic [1:0] st[3];

  int checks = 0;
  int failures = 0;

  int pq[3] = '{3, 1, 1};
  int gq[3] = '{2, 3, 2};

  // model state
  int m_cr[3];
  int m_ph[3];
  int m_next[3];
  int m_cyc = 0;
  int e_mac[3], e_hd[3], e_qt[3], e_rj[3];

  always #5 clk = ~clk;

  macguffin_vend_ctrl #(.PRICE_Q(3), .GAP_CYCLES(2)) u0 (
    .CLK50M(clk), .RES(res[0]), .Q(q[0]), .H(h[0]), .D(d[0]),
    .CANCEL(c[0]), .Macguffin0(mac[0]), .halfDollar0(hd[0]),
    .Quarter0(qt[0]), .coin_reject(rj[0]), .credit(cr[0]),
    .currentstate(st[0])
  );

  macguffin_vend_ctrl #(.PRICE_Q(1), .GAP_CYCLES(3)) u1 (
    .CLK50M(clk), .RES(res[1]), .Q(q[1]), .H(h[1]), .D(d[1]),
    .CANCEL(c[1]), .Macguffin0(mac[1]), .halfDollar0(hd[1]),
    .Quarter0(qt[1]), .coin_reject(rj[1]), .credit(cr[1]),
    .currentstate(st[1])
  );

  macguffin_vend_ctrl #(.PRICE_Q(1), .GAP_CYCLES(2)) u2 (
    .CLK50M(clk), .RES(res[2]), .Q(q[2]), .H(h[2]), .D(d[2]),
    .CANCEL(c[2]), .Macguffin0(mac[2]), .halfDollar0(hd[2]),
    .Quarter0(qt[2]), .coin_reject(rj[2]), .credit(cr[2]),
    .currentstate(st[2])
  );

  typedef struct {
    logic       res, q, h, d, c;
    logic       mac, hd, qt, rj;
    logic [3:0] cr;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic iq, logic ih, logic id, logic ic,
    logic om, logic oh, logic oq, logic orj,
    logic [3:0] ocr, logic [1:0] ost);
    vec_t v;
    v.res = r; v.q = iq; v.h = ih; v.d = id; v.c = ic;
    v.mac = om; v.hd = oh; v.qt = oq; v.rj = orj;
    v.cr = ocr; v.st = ost;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(int k, logic r, logic iq, logic ih,
                        logic id, logic ic);
    res[k] = r; q[k] = iq; h[k] = ih; d[k] = id; c[k] = ic;
  endtask

  // Spec-level model: credit in quarters, payout scheduled by
  // absolute cycle number rather than a countdown.
  task automatic model_step(int k);
    int n, v, coin;
    e_mac[k] = 0; e_hd[k] = 0; e_qt[k] = 0; e_rj[k] = 0;
    n = int'(q[k]) + int'(h[k]) + int'(d[k]);
    v = int'(q[k]) + 2 * int'(h[k]) + 4 * int'(d[k]);
    if (!res[k]) begin
      m_cr[k] = 0;
      m_ph[k] = 0;
    end else begin
      case (m_ph[k])
        0, 1: begin
          if (c[k]) begin
            e_rj[k] = (n > 0);
            if (m_cr[k] > 0) begin
              m_ph[k] = 3;
              m_next[k] = m_cyc + 1;
            end
          end else if (n > 1) begin
            e_rj[k] = 1;
          end else if (n == 1) begin
            m_cr[k] += v;
            m_ph[k] = (m_cr[k] >= pq[k]) ? 2 : 1;
          end
        end
        2: begin
          e_rj[k] = (n > 0);
          e_mac[k] = 1;
          m_cr[k] -= pq[k];
          if (m_cr[k] > 0) begin
            m_ph[k] = 3;
            m_next[k] = m_cyc + 1;
          end else begin
            m_ph[k] = 0;
          end
        end
        default: begin
          e_rj[k] = (n > 0);
          if (m_cyc == m_next[k]) begin
            coin = (m_cr[k] >= 2) ? 2 : 1;
            m_cr[k] -= coin;
            if (coin == 2) e_hd[k] = 1;
            else e_qt[k] = 1;
            if (m_cr[k] == 0) m_ph[k] = 0;
            else m_next[k] = m_cyc + gq[k] + 1;
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++) model_step(k);
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(int k);
    string p;
    p = $sformatf("rnd dut%0d cyc%0d", k, m_cyc);
    chk({p, " mac"}, 32'(mac[k]), 32'(e_mac[k]));
    chk({p, " half"}, 32'(hd[k]), 32'(e_hd[k]));
    chk({p, " qtr"}, 32'(qt[k]), 32'(e_qt[k]));
    chk({p, " rej"}, 32'(rj[k]), 32'(e_rj[k]));
    chk({p, " credit"}, 32'(cr[k]), 32'(m_cr[k]));
    chk({p, " state"}, 32'(st[k]), 32'(m_ph[k]));
  endtask

  initial begin
    int mac_at, half_at, qtr_at, nm, nh, nq;
    string p;

    for (int k = 0; k < 3; k++) begin
      set_in(k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      m_cr[k] = 0; m_ph[k] = 0; m_next[k] = 0;
    end

    // PRICE_Q=3, GAP_CYCLES=2 vector table
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,0,1,0,0, 0,0,0,0, 2,1));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 2,1));
    tbl.push_back(mk(1,0,1,0,0, 0,0,0,0, 4,2));
    tbl.push_back(mk(1,0,0,0,0, 1,0,0,0, 1,3));
    tbl.push_back(mk(1,0,0,0,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,1,0, 0,0,0,0, 4,2));
    tbl.push_back(mk(1,1,0,0,0, 1,0,0,1, 1,3));
    tbl.push_back(mk(1,0,0,0,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(1,1,0,0,0, 0,0,0,0, 1,1));
    tbl.push_back(mk(1,1,0,0,0, 0,0,0,0, 2,1));
    tbl.push_back(mk(1,0,0,0,1, 0,0,0,0, 2,3));
    tbl.push_back(mk(1,0,0,0,0, 0,1,0,0, 0,0));
    tbl.push_back(mk(1,1,1,0,0, 0,0,0,1, 0,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1,0,0,1, 0,0,0,1, 0,0));
    tbl.push_back(mk(1,1,0,0,0, 0,0,0,0, 1,1));
    tbl.push_back(mk(1,0,1,0,1, 0,0,0,1, 1,3));
    tbl.push_back(mk(1,0,0,0,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(1,1,0,0,0, 0,0,0,0, 1,1));
    tbl.push_back(mk(1,1,0,0,0, 0,0,0,0, 2,1));
    tbl.push_back(mk(1,1,0,0,0, 0,0,0,0, 3,2));
    tbl.push_back(mk(1,0,0,0,1, 1,0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(0, tbl[i].res, tbl[i].q, tbl[i].h, tbl[i].d, tbl[i].c);
      set_in(1, i != 0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_in(2, i != 0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      p = $sformatf("tbl[%0d]", i);
      chk({p, " mac"}, 32'(mac[0]), 32'(tbl[i].mac));
      chk({p, " half"}, 32'(hd[0]), 32'(tbl[i].hd));
      chk({p, " qtr"}, 32'(qt[0]), 32'(tbl[i].qt));
      chk({p, " rej"}, 32'(rj[0]), 32'(tbl[i].rj));
      chk({p, " credit"}, 32'(cr[0]), 32'(tbl[i].cr));
      chk({p, " state"}, 32'(st[0]), 32'(tbl[i].st));
    end
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // PRICE_Q=1, GAP_CYCLES=3: dollar gives half then quarter
    set_in(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("p1g3 credit after D", 32'(cr[1]), 32'd4);
    chk("p1g3 state after D", 32'(st[1]), 32'd2);
    set_in(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mac_at = -1; half_at = -1; qtr_at = -1;
    nm = 0; nh = 0; nq = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 1) chk("p1g3 credit at vend", 32'(cr[1]), 32'd3);
      if (mac[1]) begin nm++; if (mac_at < 0) mac_at = t; end
      if (hd[1]) begin nh++; if (half_at < 0) half_at = t; end
      if (qt[1]) begin nq++; if (qtr_at < 0) qtr_at = t; end
    end
    chk("p1g3 vend cycle", 32'(mac_at), 32'd1);
    chk("p1g3 half cycle", 32'(half_at), 32'd2);
    chk("p1g3 qtr cycle", 32'(qtr_at), 32'd6);
    chk("p1g3 vend count", 32'(nm), 32'd1);
    chk("p1g3 half count", 32'(nh), 32'd1);
    chk("p1g3 qtr count", 32'(nq), 32'd1);
    chk("p1g3 end state", 32'(st[1]), 32'd0);
    chk("p1g3 end credit", 32'(cr[1]), 32'd0);

    // PRICE_Q=1, GAP_CYCLES=2: reset lands in the payout gap
    set_in(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("p1g2 vend", 32'(mac[2]), 32'd1);
    tick();
    chk("p1g2 first half", 32'(hd[2]), 32'd1);
    chk("p1g2 credit after half", 32'(cr[2]), 32'd1);
    set_in(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("p1g2 rst mac", 32'(mac[2]), 32'd0);
    chk("p1g2 rst half", 32'(hd[2]), 32'd0);
    chk("p1g2 rst qtr", 32'(qt[2]), 32'd0);
    chk("p1g2 rst rej", 32'(rj[2]), 32'd0);
    chk("p1g2 rst credit", 32'(cr[2]), 32'd0);
    chk("p1g2 rst state", 32'(st[2]), 32'd0);
    set_in(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nq = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (qt[2]) nq++;
    end
    chk("p1g2 no qtr after rst", 32'(nq), 32'd0);
    chk("p1g2 idle after rst", 32'(st[2]), 32'd0);

    // random traffic on all three instances
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        set_in(k,
               (n == 0) ? 1'b0 : ($urandom_range(0, 149) != 0),
               ($urandom_range(0, 99) < 15),
               ($urandom_range(0, 99) < 12),
               ($urandom_range(0, 99) < 8),
               ($urandom_range(0, 99) < 5));
      end
      tick();
      for (int k = 0; k < 3; k++) cmp_model(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
